// File: rtl/fma_pipe_ctrl_pkg.sv
// Shared FPU definitions used by the FMA pipeline sequencer:
// default pipeline geometry and the FMA op-code encoding.
package fma_pipe_ctrl_pkg;

    localparam int FMA_STAGES = 3;
    localparam int FMA_TAGW   = 5;
    localparam int FMA_OPW    = 3;

    typedef enum logic [FMA_OPW-1:0] {
        FMA_FMADD  = 3'd0,
        FMA_FMSUB  = 3'd1,
        FMA_FNMSUB = 3'd2,
        FMA_FNMADD = 3'd3,
        FMA_FMUL   = 3'd4,
        FMA_FADD   = 3'd5,
        FMA_FSUB   = 3'd6,
        FMA_FNMUL  = 3'd7
    } fma_op_e;

endpackage

// File: rtl/fma_pipe_stage.sv
// One slot of the FMA sequencer: holds valid, destination tag and op code
// for the operation currently occupying this datapath stage.
module fma_pipe_stage
    import fma_pipe_ctrl_pkg::*;
#(
    parameter int TAGW = FMA_TAGW,
    parameter int OPW  = FMA_OPW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            advance,
    input  logic [TAGW-1:0] load_rd,
    input  logic [OPW-1:0]  load_op,
    output logic            valid,
    output logic [TAGW-1:0] rd,
    output logic [OPW-1:0]  op
);

    // Load wins over advance so a stage can hand its op forward and take
    // the next one on the same edge; flush only kills the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            rd    <= '0;
            op    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            rd    <= load_rd;
            op    <= load_op;
        end else if (advance) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fma_pipe_ctrl.sv
// Sequencer for the multi-stage FMA datapath: bubble-collapsing valid/tag
// pipeline with RAW interlock, result back-pressure and full flush.
module fma_pipe_ctrl
    import fma_pipe_ctrl_pkg::*;
#(
    parameter int STAGES = FMA_STAGES,
    parameter int TAGW   = FMA_TAGW,
    parameter int OPW    = FMA_OPW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IssueValid,
    output logic              IssueReady,
    input  logic [OPW-1:0]    IssueOp,
    input  logic [TAGW-1:0]   IssueRd,
    input  logic [TAGW-1:0]   IssueRs1,
    input  logic [TAGW-1:0]   IssueRs2,
    input  logic [TAGW-1:0]   IssueRs3,
    input  logic              IssueUsesRs3,
    input  logic              Flush,
    output logic [STAGES-1:0] StageEn,
    output logic [STAGES-1:0] StageValid,
    output logic              ResultValid,
    input  logic              ResultReady,
    output logic [TAGW-1:0]   ResultRd,
    output logic [OPW-1:0]    ResultOp,
    output logic              Hazard,
    output logic              Busy
);

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] free;
    logic [STAGES-1:0] load;
    logic [TAGW-1:0]   rd_q [STAGES];
    logic [OPW-1:0]    op_q [STAGES];
    logic              raw_match;
    logic              accept;

    // Advance is resolved from the result stage backwards so that a stage
    // sees whether its successor is vacating in the same cycle.
    always_comb begin
        adv = '0;
        free = '0;
        adv[STAGES-1] = valid[STAGES-1] & ResultReady;
        free[STAGES-1] = !valid[STAGES-1] | adv[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = valid[i] & free[i+1];
            free[i] = !valid[i] | adv[i];
        end
    end

    // Conservative interlock: an op retiring this cycle still blocks issue.
    always_comb begin
        raw_match = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (valid[i] && (rd_q[i] == IssueRs1 || rd_q[i] == IssueRs2 ||
                             (IssueUsesRs3 && rd_q[i] == IssueRs3)))
                raw_match = 1'b1;
        end
    end

    assign Hazard     = IssueValid & raw_match;
    assign IssueReady = free[0] & !Hazard & !Flush & !reset;
    assign accept     = IssueValid & IssueReady;

    always_comb begin
        load = '0;
        if (!Flush && !reset) begin
            load[0] = accept;
            for (int i = 1; i < STAGES; i++)
                load[i] = adv[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [TAGW-1:0] src_rd;
        logic [OPW-1:0]  src_op;

        if (g == 0) begin : g_head
            assign src_rd = IssueRd;
            assign src_op = IssueOp;
        end else begin : g_body
            assign src_rd = rd_q[g-1];
            assign src_op = op_q[g-1];
        end

        fma_pipe_stage #(
            .TAGW (TAGW),
            .OPW  (OPW)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (Flush),
            .load    (load[g]),
            .advance (adv[g]),
            .load_rd (src_rd),
            .load_op (src_op),
            .valid   (valid[g]),
            .rd      (rd_q[g]),
            .op      (op_q[g])
        );
    end

    assign StageEn     = load;
    assign StageValid  = valid;
    assign ResultValid = valid[STAGES-1];
    assign ResultRd    = rd_q[STAGES-1];
    assign ResultOp    = op_q[STAGES-1];
    assign Busy        = |valid;

endmodule

// File: tb/tb_fma_pipe_ctrl.sv
// Self-checking bench for fma_pipe_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a slot-level model.
module tb_fma_pipe_ctrl;

    localparam int S    = 3;
    localparam int TAGW = 5;
    localparam int OPW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic            issue_ready;
    logic [OPW-1:0]  issue_op;
    logic [TAGW-1:0] issue_rd;
    logic [TAGW-1:0] issue_rs1;
    logic [TAGW-1:0] issue_rs2;
    logic [TAGW-1:0] issue_rs3;
    logic            issue_uses_rs3;
    logic            flush;
    logic [S-1:0]    stage_en;
    logic [S-1:0]    stage_valid;
    logic            result_valid;
    logic            result_ready;
    logic [TAGW-1:0] result_rd;
    logic [OPW-1:0]  result_op;
    logic            hazard;
    logic            busy;

    int num_vec = 0;
    int num_err = 0;

    fma_pipe_ctrl #(.STAGES(S), .TAGW(TAGW), .OPW(OPW)) dut (
        .clk          (clk),
        .reset        (reset),
        .IssueValid   (issue_valid),
        .IssueReady   (issue_ready),
        .IssueOp      (issue_op),
        .IssueRd      (issue_rd),
        .IssueRs1     (issue_rs1),
        .IssueRs2     (issue_rs2),
        .IssueRs3     (issue_rs3),
        .IssueUsesRs3 (issue_uses_rs3),
        .Flush        (flush),
        .StageEn      (stage_en),
        .StageValid   (stage_valid),
        .ResultValid  (result_valid),
        .ResultReady  (result_ready),
        .ResultRd     (result_rd),
        .ResultOp     (result_op),
        .Hazard       (hazard),
        .Busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: each slot either holds an op or is a hole. An op moves one slot
    // forward whenever any hole exists ahead of it (the result slot counts
    // as a hole when it is being consumed).
    bit              m_v  [S];
    logic [TAGW-1:0] m_rd [S];
    logic [OPW-1:0]  m_op [S];
    bit              model_on = 1'b0;

    bit              e_mv [S];
    bit              e_hazard;
    bit              e_ready;
    bit              e_accept;
    logic [S-1:0]    e_en;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_vec++;
        if (act !== exp) begin
            num_err++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void compute_expect();
        bit hole;
        bit free0;
        for (int i = 0; i < S; i++) begin
            hole = 1'b0;
            for (int j = i + 1; j < S; j++)
                if (!m_v[j] || (j == S - 1 && result_ready)) hole = 1'b1;
            e_mv[i] = m_v[i] && ((i == S - 1) ? result_ready : hole);
        end
        e_hazard = 1'b0;
        if (issue_valid)
            for (int i = 0; i < S; i++)
                if (m_v[i] && (m_rd[i] == issue_rs1 || m_rd[i] == issue_rs2 ||
                               (issue_uses_rs3 && m_rd[i] == issue_rs3)))
                    e_hazard = 1'b1;
        free0    = !m_v[0] || e_mv[0];
        e_ready  = free0 && !e_hazard && !flush && !reset;
        e_accept = issue_valid && e_ready;
        e_en     = '0;
        if (!flush && !reset) begin
            e_en[0] = e_accept;
            for (int i = 1; i < S; i++) e_en[i] = e_mv[i-1];
        end
    endfunction

    task automatic update_model();
        bit              nv  [S];
        logic [TAGW-1:0] nrd [S];
        logic [OPW-1:0]  nop [S];
        compute_expect();
        if (reset) begin
            for (int i = 0; i < S; i++) begin
                m_v[i] = 1'b0; m_rd[i] = '0; m_op[i] = '0;
            end
            model_on = 1'b1;
        end else if (flush) begin
            for (int i = 0; i < S; i++) m_v[i] = 1'b0;
        end else begin
            for (int i = S - 1; i >= 1; i--) begin
                if (e_mv[i-1]) begin
                    nv[i] = 1'b1; nrd[i] = m_rd[i-1]; nop[i] = m_op[i-1];
                end else begin
                    nv[i] = m_v[i] && !e_mv[i]; nrd[i] = m_rd[i]; nop[i] = m_op[i];
                end
            end
            if (e_accept) begin
                nv[0] = 1'b1; nrd[0] = issue_rd; nop[0] = issue_op;
            end else begin
                nv[0] = m_v[0] && !e_mv[0]; nrd[0] = m_rd[0]; nop[0] = m_op[0];
            end
            for (int i = 0; i < S; i++) begin
                m_v[i] = nv[i]; m_rd[i] = nrd[i]; m_op[i] = nop[i];
            end
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        logic [S-1:0] mv_vec;
        forever begin
            @(negedge clk);
            if (model_on) begin
                compute_expect();
                for (int i = 0; i < S; i++) mv_vec[i] = m_v[i];
                checkOutput("model StageValid", 32'(stage_valid), 32'(mv_vec));
                checkOutput("model ResultValid", 32'(result_valid), 32'(m_v[S-1]));
                checkOutput("model Busy", 32'(busy), 32'(|mv_vec));
                checkOutput("model Hazard", 32'(hazard), 32'(e_hazard));
                checkOutput("model IssueReady", 32'(issue_ready), 32'(e_ready));
                checkOutput("model StageEn", 32'(stage_en), 32'(e_en));
                if (m_v[S-1]) begin
                    checkOutput("model ResultRd", 32'(result_rd), 32'(m_rd[S-1]));
                    checkOutput("model ResultOp", 32'(result_op), 32'(m_op[S-1]));
                end
            end
            @(posedge clk);
            update_model();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setInputs(input logic iv, input logic [TAGW-1:0] rd, input logic [OPW-1:0] op,
                             input logic [TAGW-1:0] rs1, input logic [TAGW-1:0] rs2,
                             input logic [TAGW-1:0] rs3, input logic u3);
        issue_valid = iv; issue_rd = rd; issue_op = op;
        issue_rs1 = rs1; issue_rs2 = rs2; issue_rs3 = rs3; issue_uses_rs3 = u3;
    endtask

    task automatic applyStimulus(input logic iv, input logic [TAGW-1:0] rd, input logic [OPW-1:0] op,
                                 input logic [TAGW-1:0] rs1, input logic [TAGW-1:0] rs2,
                                 input logic [TAGW-1:0] rs3, input logic u3);
        setInputs(iv, rd, op, rs1, rs2, rs3, u3);
        tick();
    endtask

    task automatic idle();
        setInputs(1'b0, '0, '0, 5'd30, 5'd30, 5'd30, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; result_ready = 1'b1;
        idle();
        tick();
        tick();

        // Reset state
        reset = 1'b0;
        #1;
        checkOutput("reset StageValid", 32'(stage_valid), 32'h0);
        checkOutput("reset ResultValid", 32'(result_valid), 32'h0);
        checkOutput("reset ResultRd", 32'(result_rd), 32'h0);
        checkOutput("reset ResultOp", 32'(result_op), 32'h0);
        checkOutput("reset Busy", 32'(busy), 32'h0);
        checkOutput("reset StageEn", 32'(stage_en), 32'h0);
        checkOutput("reset Hazard", 32'(hazard), 32'h0);
        checkOutput("reset IssueReady", 32'(issue_ready), 32'h1);
        tick();

        // In-order issue of three independent ops
        setInputs(1'b1, 5'd1, 3'd4, 5'd10, 5'd11, 5'd12, 1'b1);
        #1 checkOutput("walk StageEn 1", 32'(stage_en), 32'h1);
        tick();
        setInputs(1'b1, 5'd2, 3'd5, 5'd10, 5'd11, 5'd12, 1'b1);
        #1 checkOutput("walk StageEn 2", 32'(stage_en), 32'h3);
        tick();
        setInputs(1'b1, 5'd3, 3'd1, 5'd10, 5'd11, 5'd12, 1'b1);
        #1 checkOutput("walk StageEn 3", 32'(stage_en), 32'h7);
        tick();
        idle();
        checkOutput("walk first ResultValid", 32'(result_valid), 32'h1);
        checkOutput("walk ResultRd 1", 32'(result_rd), 32'd1);
        checkOutput("walk ResultOp 1", 32'(result_op), 32'd4);
        tick();
        checkOutput("walk ResultRd 2", 32'(result_rd), 32'd2);
        checkOutput("walk ResultOp 2", 32'(result_op), 32'd5);
        tick();
        checkOutput("walk ResultRd 3", 32'(result_rd), 32'd3);
        checkOutput("walk ResultOp 3", 32'(result_op), 32'd1);
        tick();
        checkOutput("walk drained", 32'(busy), 32'h0);

        // RAW interlock held until the producer retires
        applyStimulus(1'b1, 5'd4, 3'd2, 5'd20, 5'd21, 5'd22, 1'b1);
        setInputs(1'b1, 5'd8, 3'd0, 5'd4, 5'd21, 5'd22, 1'b1);
        #1;
        checkOutput("raw Hazard", 32'(hazard), 32'h1);
        checkOutput("raw IssueReady", 32'(issue_ready), 32'h0);
        tick();
        tick();
        checkOutput("raw producer ResultRd", 32'(result_rd), 32'd4);
        checkOutput("raw Hazard at completion", 32'(hazard), 32'h1);
        tick();
        checkOutput("raw Hazard cleared", 32'(hazard), 32'h0);
        checkOutput("raw IssueReady after retire", 32'(issue_ready), 32'h1);
        tick();
        checkOutput("raw dependent accepted", 32'(stage_valid), 32'h1);
        idle();
        tick(); tick(); tick();
        checkOutput("raw drained", 32'(busy), 32'h0);

        // Back-pressure
        result_ready = 1'b0;
        applyStimulus(1'b1, 5'd5, 3'd3, 5'd24, 5'd25, 5'd26, 1'b1);
        applyStimulus(1'b1, 5'd6, 3'd3, 5'd24, 5'd25, 5'd26, 1'b1);
        applyStimulus(1'b1, 5'd7, 3'd3, 5'd24, 5'd25, 5'd26, 1'b1);
        setInputs(1'b1, 5'd9, 3'd6, 5'd27, 5'd28, 5'd29, 1'b1);
        #1;
        checkOutput("stall full StageValid", 32'(stage_valid), 32'h7);
        checkOutput("stall IssueReady", 32'(issue_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("stall ResultRd held", 32'(result_rd), 32'd5);
        end
        idle();
        result_ready = 1'b1;
        tick();
        checkOutput("release ResultRd 6", 32'(result_rd), 32'd6);
        tick();
        checkOutput("release ResultRd 7", 32'(result_rd), 32'd7);
        tick();
        checkOutput("release drained", 32'(result_valid), 32'h0);

        // Flush with a concurrent issue, then reset in the middle of a stall
        applyStimulus(1'b1, 5'd10, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        applyStimulus(1'b1, 5'd11, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        applyStimulus(1'b1, 5'd12, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        setInputs(1'b1, 5'd13, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        flush = 1'b1;
        #1;
        checkOutput("flush IssueReady", 32'(issue_ready), 32'h0);
        checkOutput("flush StageEn", 32'(stage_en), 32'h0);
        tick();
        flush = 1'b0;
        idle();
        checkOutput("flush Busy", 32'(busy), 32'h0);
        checkOutput("flush ResultValid", 32'(result_valid), 32'h0);
        checkOutput("flush StageValid", 32'(stage_valid), 32'h0);
        result_ready = 1'b0;
        applyStimulus(1'b1, 5'd14, 3'd7, 5'd1, 5'd2, 5'd3, 1'b1);
        applyStimulus(1'b1, 5'd15, 3'd7, 5'd1, 5'd2, 5'd3, 1'b1);
        idle();
        reset = 1'b1;
        tick();
        checkOutput("midreset Busy", 32'(busy), 32'h0);
        checkOutput("midreset StageValid", 32'(stage_valid), 32'h0);
        checkOutput("midreset ResultRd", 32'(result_rd), 32'h0);
        checkOutput("midreset ResultOp", 32'(result_op), 32'h0);
        reset = 1'b0;
        result_ready = 1'b1;
        tick();

        // Rs3 only participates when the op uses it
        applyStimulus(1'b1, 5'd15, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        setInputs(1'b1, 5'd16, 3'd0, 5'd20, 5'd21, 5'd15, 1'b0);
        #1;
        checkOutput("rs3 unused Hazard", 32'(hazard), 32'h0);
        checkOutput("rs3 unused IssueReady", 32'(issue_ready), 32'h1);
        issue_uses_rs3 = 1'b1;
        #1;
        checkOutput("rs3 used Hazard", 32'(hazard), 32'h1);
        checkOutput("rs3 used IssueReady", 32'(issue_ready), 32'h0);
        idle();
        tick(); tick(); tick();

        // Randomized traffic with small tag space to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            result_ready = ($urandom_range(0, 9) < 7);
            applyStimulus($urandom_range(0, 9) < 7,
                          TAGW'($urandom_range(0, 7)), OPW'($urandom_range(0, 7)),
                          TAGW'($urandom_range(0, 7)), TAGW'($urandom_range(0, 7)),
                          TAGW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        reset = 1'b0; flush = 1'b0; result_ready = 1'b1;
        idle();
        tick(); tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
        $finish;
    end

endmodule
